// File: rtl/sonic_echo_responder.sv
// rtl/sonic_echo_responder.sv - HC-SR04 style echo emulator; define ECHO_JITTER_EN to add LFSR echo-width jitter
module sonic_echo_responder #(
  parameter int US_CYCLES   = 100,
  parameter int MIN_TRIG_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MIN_CM      = 2,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [9:0] distance_cm,
  input  logic       obstacle,
  output logic       echo,
  output logic       busy,
  output logic       trig_err,
  output logic [7:0] meas_cnt
);

  localparam int PW = (US_CYCLES > 1) ? $clog2(US_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(US_CYCLES - 1);
  localparam logic [15:0]   MIN_TRIG     = 16'(MIN_TRIG_US);
  localparam logic [15:0]   BURST_LAST   = 16'(BURST_US - 1);
  localparam logic [15:0]   HOLDOFF_LAST = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]   MIN_D        = 16'(MIN_CM);
  localparam logic [15:0]   MAX_D        = 16'(MAX_CM);
  localparam logic [15:0]   PER_CM       = 16'(US_PER_CM);
  localparam logic [15:0]   TIMEOUT      = 16'(TIMEOUT_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG_HI,
    S_BURST,
    S_ECHO,
    S_HOLDOFF
  } state_t;

  state_t state, state_next;

  logic          trig_s1, trig_s2, trig_d;
  logic [PW-1:0] presc;
  logic [15:0]   us_cnt;
  logic          tick;
  logic [9:0]    dist_q;
  logic          obs_q;
  logic [15:0]   dist_ext, dist_clamped, echo_base, echo_us, echo_last;
  logic          trig_rise, width_ok, accept, reject;

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_s1 <= 1'b0;
      trig_s2 <= 1'b0;
      trig_d  <= 1'b0;
    end else begin
      trig_s1 <= trig;
      trig_s2 <= trig_s1;
      trig_d  <= trig_s2;
    end
  end

  assign tick      = (presc == PRESC_LAST);
  assign trig_rise = trig_s2 & ~trig_d;
  // The cycle on which the fall is seen still completes the last microsecond
  assign width_ok  = ({1'b0, us_cnt} + {16'd0, tick}) >= {1'b0, MIN_TRIG};
  assign accept    = (state == S_TRIG_HI) && !trig_s2 && width_ok;
  assign reject    = (state == S_TRIG_HI) && !trig_s2 && !width_ok;

  // Echo width in microseconds from the snapshotted distance
  always_comb begin
    dist_ext     = {6'd0, dist_q};
    dist_clamped = (dist_ext < MIN_D) ? MIN_D : dist_ext;
    echo_base    = TIMEOUT;
    if (obs_q && (dist_ext <= MAX_D)) begin
      echo_base = dist_clamped * PER_CM;
    end
  end

`ifdef ECHO_JITTER_EN
  logic [7:0] lfsr;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per accepted trig
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign echo_us = echo_base + {13'd0, lfsr[2:0]};
`else
  assign echo_us = echo_base;
`endif

  assign echo_last = echo_us - 16'd1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; trig is only looked at in IDLE and TRIG_HI
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (trig_rise) state_next = S_TRIG_HI;
      end
      S_TRIG_HI: begin
        if (!trig_s2) state_next = width_ok ? S_BURST : S_IDLE;
      end
      S_BURST: begin
        if (tick && (us_cnt == BURST_LAST)) state_next = S_ECHO;
      end
      S_ECHO: begin
        if (tick && (us_cnt == echo_last)) state_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (tick && (us_cnt == HOLDOFF_LAST)) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Combinational outputs decoded from the state
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Microsecond prescaler and counter, both restart on every state entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else if (state_next != state) begin
      presc  <= '0;
      us_cnt <= 16'd0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick && (us_cnt != 16'hFFFF)) us_cnt <= us_cnt + 16'd1;
    end
  end

  // Snapshot of the target so later input changes leave the pulse in flight alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_q <= 10'd0;
      obs_q  <= 1'b0;
    end else if (accept) begin
      dist_q <= distance_cm;
      obs_q  <= obstacle;
    end
  end

  // Registered outputs; echo rises and falls on the ECHO entry and exit edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo     <= 1'b0;
      trig_err <= 1'b0;
      meas_cnt <= 8'd0;
    end else begin
      echo     <= (state_next == S_ECHO);
      trig_err <= reject;
      if ((state == S_ECHO) && (state_next == S_HOLDOFF)) meas_cnt <= meas_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sonic_echo_responder.sv
// tb/tb_sonic_echo_responder.sv - scoreboard bench for sonic_echo_responder with scaled-down timing
module tb_sonic_echo_responder;

  localparam int U     = 4;
  localparam int MIN_T = 10;
  localparam int B     = 20;
  localparam int UPC   = 3;
  localparam int MINC  = 2;
  localparam int MAXC  = 40;
  localparam int TO    = 150;
  localparam int H     = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [9:0] distance_cm = 10'd0;
  logic       obstacle = 1'b0;
  logic       echo, busy, trig_err;
  logic [7:0] meas_cnt;

  typedef struct {
    bit         is_err;
    int         at_cyc;
    int         width;
    logic [7:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] mcnt = 8'd0;

  sonic_echo_responder #(
    .US_CYCLES(U), .MIN_TRIG_US(MIN_T), .BURST_US(B), .US_PER_CM(UPC),
    .MIN_CM(MINC), .MAX_CM(MAXC), .TIMEOUT_US(TO), .HOLDOFF_US(H)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm), .obstacle(obstacle),
    .echo(echo), .busy(busy), .trig_err(trig_err), .meas_cnt(meas_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int echo_width_us(input int d, input bit obs);
    if (!obs || d > MAXC) return TO;
    return ((d < MINC) ? MINC : d) * UPC;
  endfunction

  // Monitor: pops an expectation whenever the DUT presents trig_err or an echo rise
  bit   in_echo = 0;
  bit   err_chk = 0;
  int   ew = 0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      in_echo = 0;
      err_chk = 0;
    end else begin
      if (err_chk) begin
        check("trig_err_one_cycle", trig_err, 0);
        err_chk = 0;
      end else if (trig_err) begin
        check("trig_err_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("trig_err_is_error", cur.is_err, 1);
          check("trig_err_cycle", cyc, cur.at_cyc);
          err_chk = 1;
        end
      end
      if (echo && !in_echo) begin
        check("echo_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("echo_not_error", cur.is_err, 0);
          check("echo_rise_cycle", cyc, cur.at_cyc);
        end
        in_echo = 1;
        ew = 1;
      end else if (echo && in_echo) begin
        ew++;
      end else if (!echo && in_echo) begin
        check("echo_width", ew, cur.width);
        check("meas_cnt_after_echo", meas_cnt, cur.cnt);
        in_echo = 0;
      end
    end
  end

  // Stimulus: a trig pulse of 'width' cycles; the expected outcome is queued at the fall
  task automatic do_trig(input int width, input int d, input bit obs);
    exp_t e;
    int   fall;
    distance_cm = 10'(d);
    obstacle    = obs;
    @(posedge clk);
    #1 trig = 1'b1;
    repeat (width) @(posedge clk);
    #1 trig = 1'b0;
    fall = cyc;
    if (width >= MIN_T * U) begin
      mcnt     = mcnt + 8'd1;
      e.is_err = 0;
      e.at_cyc = fall + 3 + B * U;
      e.width  = echo_width_us(d, obs) * U;
      e.cnt    = mcnt;
    end else begin
      e.is_err = 1;
      e.at_cyc = fall + 3;
      e.width  = 0;
      e.cnt    = mcnt;
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    repeat (4) @(posedge clk);
    #1;
    distance_cm = 10'($urandom_range(0, 1023));
    obstacle    = 1'($urandom_range(0, 1));
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_within_budget", busy, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_echo(input logic lvl);
    int n;
    n = 0;
    while (echo !== lvl && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("echo_level_reached", echo, lvl);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_echo", echo, 0);
    check("reset_busy", busy, 0);
    check("reset_trig_err", trig_err, 0);
    check("reset_meas_cnt", meas_cnt, 0);
    repeat (2) @(posedge clk);

    do_trig(MIN_T * U, 20, 1);       wait_idle();
    do_trig(MIN_T * U - 1, 20, 1);   wait_idle();
    check("meas_cnt_after_reject", meas_cnt, mcnt);
    do_trig(MIN_T * U, 20, 0);       wait_idle();
    do_trig(MIN_T * U, MAXC + 1, 1); wait_idle();
    do_trig(MIN_T * U, MAXC, 1);     wait_idle();
    do_trig(MIN_T * U, 0, 1);        wait_idle();
    do_trig(MIN_T * U, 1, 1);        wait_idle();
    do_trig(MIN_T * U, MINC, 1);     wait_idle();
    do_trig(MIN_T * U, 1023, 1);     wait_idle();
    do_trig(1, 5, 1);                wait_idle();

    // Trig and distance changes during ECHO, then a trig held across HOLDOFF
    do_trig(MIN_T * U + 5, 20, 1);
    wait_echo(1'b1);
    repeat (5) @(posedge clk);
    #1 distance_cm = 10'd100;
    check("busy_in_echo", busy, 1);
    trig = 1'b1;
    repeat (MIN_T * U + 8) @(posedge clk);
    #1 trig = 1'b0;
    wait_echo(1'b0);
    trig = 1'b1;
    repeat (MIN_T * U + 2) @(posedge clk);
    #1 trig = 1'b0;
    wait_idle();
    do_trig(MIN_T * U, 7, 1);        wait_idle();

    for (int i = 0; i < 25; i++) begin
      int w, d;
      bit o;
      case ($urandom_range(0, 3))
        0:       w = MIN_T * U - 1;
        1:       w = MIN_T * U;
        2:       w = $urandom_range(1, MIN_T * U - 2);
        default: w = $urandom_range(MIN_T * U + 1, 3 * MIN_T * U);
      endcase
      d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 50);
      o = ($urandom_range(0, 7) != 0);
      do_trig(w, d, o);
      wait_idle();
    end

    // Reset in the middle of an echo
    do_trig(MIN_T * U + 3, 30, 1);
    wait_echo(1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_echo_low", echo, 0);
    check("rst_meas_cnt", meas_cnt, 0);
    check("rst_busy", busy, 0);
    mcnt = 8'd0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    do_trig(MIN_T * U, 25, 1);       wait_idle();

    repeat (10) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
